// File: rtl/interp_regs_pkg.sv
// Shared constants for the interpolator register block: register indices,
// CONTROL and COMMIT bit positions, and reset values.
package interp_regs_pkg;

    localparam int CTRL_W = 5;

    localparam logic [2:0] REG_CONTROL  = 3'd0;
    localparam logic [2:0] REG_MANTISSA = 3'd1;
    localparam logic [2:0] REG_EXPONENT = 3'd2;
    localparam logic [2:0] REG_TEST     = 3'd3;
    localparam logic [2:0] REG_COMMIT   = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_BYPASS   = 0;
    localparam int CTRL_TEST     = 1;
    localparam int CTRL_INVERT   = 2;
    localparam int CTRL_BYPASSEQ = 3;
    localparam int CTRL_RAMP     = 4;

    localparam int COMMIT_SELF = 0;
    localparam int COMMIT_ALL  = 1;
    localparam int COMMIT_NOW  = 2;

    localparam logic [CTRL_W-1:0] CTRL_RESET    = 5'b00001;
    localparam logic              PENDING_RESET = 1'b0;

endpackage

// File: rtl/interp_chan_regs.sv
// One interpolator channel: shadow/active register pair, pending flag and the
// optional test-value ramp (enabled by INTERP_TEST_RAMP_EN).
module interp_chan_regs
    import interp_regs_pkg::*;
#(
    parameter int MANT_W = 18,
    parameter int EXP_W  = 5
) (
    input  logic              busClk,
    input  logic              reset,
    input  logic [MANT_W-1:0] wrData,
    input  logic [MANT_W-1:0] wrMask,
    input  logic              wrCtrl,
    input  logic              wrMant,
    input  logic              wrExp,
    input  logic              wrTest,
    input  logic              setPending,
    input  logic              forceCopy,
    input  logic              updateStrobe,
    output logic [CTRL_W-1:0] shadowCtrl,
    output logic [MANT_W-1:0] shadowMant,
    output logic [EXP_W-1:0]  shadowExp,
    output logic [MANT_W-1:0] shadowTest,
    output logic [3:0]        activeFlags,
    output logic [MANT_W-1:0] activeMant,
    output logic [EXP_W-1:0]  activeExp,
    output logic [MANT_W-1:0] activeTest,
    output logic              pending
);

`ifdef INTERP_TEST_RAMP_EN
    localparam logic [CTRL_W-1:0] CTRL_KEEP = 5'h1F;
    logic activeRamp;
`else
    localparam logic [CTRL_W-1:0] CTRL_KEEP = 5'h0F;
`endif

    logic transfer;
    assign transfer = forceCopy || (pending && updateStrobe);

    // Active copies read the pre-edge shadow, so a coincident write lands only in the shadow.
    always_ff @(posedge busClk) begin
        if (reset) begin
            shadowCtrl  <= CTRL_RESET;
            shadowMant  <= '0;
            shadowExp   <= '0;
            shadowTest  <= '0;
            activeFlags <= CTRL_RESET[3:0];
            activeMant  <= '0;
            activeExp   <= '0;
            activeTest  <= '0;
            pending     <= PENDING_RESET;
`ifdef INTERP_TEST_RAMP_EN
            activeRamp  <= CTRL_RESET[CTRL_RAMP];
`endif
        end else begin
            if (wrCtrl)
                shadowCtrl <= ((shadowCtrl & ~wrMask[CTRL_W-1:0]) | (wrData[CTRL_W-1:0] & wrMask[CTRL_W-1:0])) & CTRL_KEEP;
            if (wrMant)
                shadowMant <= (shadowMant & ~wrMask) | (wrData & wrMask);
            if (wrExp)
                shadowExp <= (shadowExp & ~wrMask[EXP_W-1:0]) | (wrData[EXP_W-1:0] & wrMask[EXP_W-1:0]);
            if (wrTest)
                shadowTest <= (shadowTest & ~wrMask) | (wrData & wrMask);

            if (transfer) begin
                activeFlags <= shadowCtrl[3:0];
                activeMant  <= shadowMant;
                activeExp   <= shadowExp;
                activeTest  <= shadowTest;
`ifdef INTERP_TEST_RAMP_EN
                activeRamp  <= shadowCtrl[CTRL_RAMP];
            end else if (updateStrobe && activeFlags[CTRL_TEST] && activeRamp) begin
                activeTest  <= activeTest + MANT_W'(1);
`endif
            end

            // A commit landing on a transfer edge re-arms for the next boundary.
            if (forceCopy)
                pending <= 1'b0;
            else if (setPending)
                pending <= 1'b1;
            else if (transfer)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interp_regs_mc.sv
// Interpolator register block top: address decode, commit fan-out, read mux.
// Optional test-value ramp is built when INTERP_TEST_RAMP_EN is defined.
module interp_regs_mc
    import interp_regs_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MANT_W = 18,
    parameter int EXP_W  = 5
) (
    input  logic                     busClk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic [12:0]              addr,
    input  logic [31:0]              dataIn,
    input  logic                     wr0,
    input  logic                     wr1,
    input  logic                     wr2,
    input  logic                     wr3,
    output logic [31:0]              dataOut,
    input  logic [NUM_CH-1:0]        updateStrobe,
    output logic [NUM_CH-1:0]        bypass,
    output logic [NUM_CH-1:0]        test,
    output logic [NUM_CH-1:0]        invert,
    output logic [NUM_CH-1:0]        bypassEQ,
    output logic [NUM_CH*MANT_W-1:0] mantissa,
    output logic [NUM_CH*EXP_W-1:0]  exponent,
    output logic [NUM_CH*MANT_W-1:0] testValue
);

    logic [2:0]        idx;
    logic [2:0]        ch;
    logic              chMapped;
    logic              commitWr;
    logic [MANT_W-1:0] wrMask;
    logic [NUM_CH-1:0] pending;
    logic              unusedBits;

    logic [CTRL_W-1:0] shadowCtrl [NUM_CH];
    logic [MANT_W-1:0] shadowMant [NUM_CH];
    logic [EXP_W-1:0]  shadowExp  [NUM_CH];
    logic [MANT_W-1:0] shadowTest [NUM_CH];
    logic [3:0]        activeFlags[NUM_CH];

    assign idx        = addr[4:2];
    assign ch         = addr[7:5];
    assign chMapped   = int'(ch) < NUM_CH;
    assign commitWr   = cs && chMapped && (idx == REG_COMMIT) && wr0;
    assign wrMask     = MANT_W'({{8{wr3}}, {8{wr2}}, {8{wr1}}, {8{wr0}}});
    assign unusedBits = ^{addr[12:8], addr[1:0], dataIn[31:MANT_W], wr3};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = cs && chMapped && (ch == 3'(i));

        interp_chan_regs #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_chan (
            .busClk       (busClk),
            .reset        (reset),
            .wrData       (dataIn[MANT_W-1:0]),
            .wrMask       (wrMask),
            .wrCtrl       (hit && idx == REG_CONTROL),
            .wrMant       (hit && idx == REG_MANTISSA),
            .wrExp        (hit && idx == REG_EXPONENT),
            .wrTest       (hit && idx == REG_TEST),
            .setPending   (commitWr && ((hit && dataIn[COMMIT_SELF]) || dataIn[COMMIT_ALL])),
            .forceCopy    (commitWr && hit && dataIn[COMMIT_NOW]),
            .updateStrobe (updateStrobe[i]),
            .shadowCtrl   (shadowCtrl[i]),
            .shadowMant   (shadowMant[i]),
            .shadowExp    (shadowExp[i]),
            .shadowTest   (shadowTest[i]),
            .activeFlags  (activeFlags[i]),
            .activeMant   (mantissa[i*MANT_W +: MANT_W]),
            .activeExp    (exponent[i*EXP_W +: EXP_W]),
            .activeTest   (testValue[i*MANT_W +: MANT_W]),
            .pending      (pending[i])
        );

        assign bypass[i]   = activeFlags[i][CTRL_BYPASS];
        assign test[i]     = activeFlags[i][CTRL_TEST];
        assign invert[i]   = activeFlags[i][CTRL_INVERT];
        assign bypassEQ[i] = activeFlags[i][CTRL_BYPASSEQ];
    end

    always_comb begin
        dataOut = '0;
        if (cs && chMapped) begin
            if (idx == REG_STATUS) begin
                dataOut = {24'h0, 8'(pending)};
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch == 3'(i)) begin
                        case (idx)
                            REG_CONTROL:  dataOut = 32'(shadowCtrl[i]);
                            REG_MANTISSA: dataOut = 32'(shadowMant[i]);
                            REG_EXPONENT: dataOut = 32'(shadowExp[i]);
                            REG_TEST:     dataOut = 32'(shadowTest[i]);
                            default:      dataOut = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_interp_regs_mc.sv
// Directed test of interp_regs_mc with default parameters (4 channels, 18-bit
// mantissa, 5-bit exponent); ramp checks depend on INTERP_TEST_RAMP_EN.
module tb_interp_regs_mc;

    logic        busClk = 1'b0;
    logic        reset  = 1'b1;
    logic        cs     = 1'b0;
    logic [12:0] addr   = '0;
    logic [31:0] dataIn = '0;
    logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
    logic [31:0] dataOut;
    logic [3:0]  updateStrobe = '0;
    logic [3:0]  bypass, test, invert, bypassEQ;
    logic [71:0] mantissa, testValue;
    logic [19:0] exponent;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] rd;

    interp_regs_mc dut (
        .busClk(busClk), .reset(reset), .cs(cs), .addr(addr), .dataIn(dataIn),
        .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3), .dataOut(dataOut),
        .updateStrobe(updateStrobe), .bypass(bypass), .test(test), .invert(invert),
        .bypassEQ(bypassEQ), .mantissa(mantissa), .exponent(exponent), .testValue(testValue)
    );

    always #5 busClk = ~busClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] lanes);
        @(negedge busClk);
        cs = 1'b1; addr = a; dataIn = d;
        {wr3, wr2, wr1, wr0} = lanes;
        @(posedge busClk); #1;
        cs = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0; dataIn = '0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [31:0] d);
        @(negedge busClk);
        cs = 1'b1; addr = a; {wr3, wr2, wr1, wr0} = 4'b0;
        #1 d = dataOut;
        cs = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] m);
        @(negedge busClk);
        updateStrobe = m;
        @(posedge busClk); #1;
        updateStrobe = '0;
    endtask

    initial begin
        // Reset held for two edges; outputs checked while reset is still high
        repeat (2) @(posedge busClk);
        #1;
        check("rst_bypass", 32'(bypass), 32'hF);
        check("rst_mantissa_ch2", 32'(mantissa[36 +: 18]), 32'h0);
        @(negedge busClk) reset = 1'b0;

        bus_read(13'h000, rd); check("rst_ctrl_ch0", rd, 32'h1);
        bus_read(13'h010, rd); check("rst_status", rd, 32'h0);

        // Shadow write with no commit: strobe leaves active alone
        bus_write(13'h044, 32'h0003_1234, 4'hF);
        strobe(4'b0100);
        check("nocommit_mant_ch2", 32'(mantissa[36 +: 18]), 32'h0);
        bus_read(13'h044, rd); check("shadow_mant_ch2", rd, 32'h0003_1234);

        // Commit ch2, then strobe
        bus_write(13'h050, 32'h1, 4'b0001);
        bus_read(13'h010, rd); check("status_ch2_pend", rd, 32'h4);
        strobe(4'b0100);
        check("xfer_mant_ch2", 32'(mantissa[36 +: 18]), 32'h31234);
        bus_read(13'h010, rd); check("status_after_xfer", rd, 32'h0);

        // Commit-all, strobe only ch1
        bus_write(13'h024, 32'h0000_0ABC, 4'hF);
        bus_write(13'h010, 32'h2, 4'b0001);
        bus_read(13'h010, rd); check("status_all_pend", rd, 32'hF);
        strobe(4'b0010);
        check("all_mant_ch1", 32'(mantissa[18 +: 18]), 32'hABC);
        check("all_mant_ch0", 32'(mantissa[0 +: 18]), 32'h0);
        bus_read(13'h010, rd); check("status_D", rd, 32'hD);

        // Shadow write coincident with transfer on ch3
        bus_write(13'h068, 32'h7, 4'hF);
        @(negedge busClk);
        cs = 1'b1; addr = 13'h068; dataIn = 32'h1F; {wr3, wr2, wr1, wr0} = 4'hF;
        updateStrobe = 4'b1000;
        @(posedge busClk); #1;
        cs = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0; updateStrobe = '0;
        check("coinc_active_exp", 32'(exponent[15 +: 5]), 32'h07);
        bus_read(13'h068, rd); check("coinc_shadow_exp", rd, 32'h1F);
        bus_read(13'h010, rd); check("coinc_status", rd, 32'h5);

        // CONTROL unused bits, then immediate copy on ch0
        bus_write(13'h000, 32'hFFFF_FFFF, 4'hF);
        bus_read(13'h000, rd);
`ifdef INTERP_TEST_RAMP_EN
        check("ctrl_mask", rd, 32'h1F);
`else
        check("ctrl_mask", rd, 32'h0F);
`endif
        bus_write(13'h010, 32'h4, 4'b0001);
        check("force_flags_ch0", {28'h0, bypassEQ[0], invert[0], test[0], bypass[0]}, 32'hF);
        bus_read(13'h010, rd); check("force_status", rd, 32'h4);

        // Commit on ch2 coincident with a ch2 transfer: transfer happens, pending stays
        bus_write(13'h044, 32'h55, 4'hF);
        @(negedge busClk);
        cs = 1'b1; addr = 13'h050; dataIn = 32'h1; wr0 = 1'b1;
        updateStrobe = 4'b0100;
        @(posedge busClk); #1;
        cs = 1'b0; wr0 = 1'b0; dataIn = '0; updateStrobe = '0;
        check("commit_xfer_mant", 32'(mantissa[36 +: 18]), 32'h55);
        bus_read(13'h010, rd); check("commit_xfer_status", rd, 32'h4);

        // Strobe without pending
        bus_write(13'h024, 32'h111, 4'hF);
        strobe(4'b0010);
        check("nopend_mant_ch1", 32'(mantissa[18 +: 18]), 32'hABC);

        // Byte-lane writes and truncation on ch3 mantissa
        bus_write(13'h064, 32'hFFFF_FFFF, 4'hF);
        bus_read(13'h064, rd); check("trunc_mant_ch3", rd, 32'h3FFFF);
        bus_write(13'h064, 32'h0, 4'b0010);
        bus_read(13'h064, rd); check("lane1_mant_ch3", rd, 32'h300FF);

        // Unmapped channel / index, and cs low
        bus_write(13'h0A4, 32'h1234, 4'hF);
        bus_read(13'h0A4, rd); check("unmapped_ch_rd", rd, 32'h0);
        bus_read(13'h024, rd); check("unmapped_no_alias", rd, 32'h111);
        bus_read(13'h014, rd); check("unmapped_idx_rd", rd, 32'h0);
        @(negedge busClk);
        cs = 1'b0; addr = 13'h024;
        #1 check("cs_low_rd", dataOut, 32'h0);

`ifdef INTERP_TEST_RAMP_EN
        bus_write(13'h00C, 32'h3FFFE, 4'hF);
        bus_write(13'h000, 32'h12, 4'hF);
        bus_write(13'h010, 32'h1, 4'b0001);
        strobe(4'b0001);
        check("ramp_load", 32'(testValue[0 +: 18]), 32'h3FFFE);
        check("ramp_ctrl", {30'h0, test[0], bypass[0]}, 32'h2);
        strobe(4'b0001); check("ramp_1", 32'(testValue[0 +: 18]), 32'h3FFFF);
        strobe(4'b0001); check("ramp_wrap", 32'(testValue[0 +: 18]), 32'h0);
        strobe(4'b0001); check("ramp_3", 32'(testValue[0 +: 18]), 32'h1);
`else
        bus_write(13'h020, 32'h12, 4'hF);
        bus_read(13'h020, rd); check("no_ramp_bit", rd, 32'h2);
`endif

        // Reset beats a coincident write and strobe, and drops pending
        bus_write(13'h030, 32'h1, 4'b0001);
        @(negedge busClk);
        reset = 1'b1; cs = 1'b1; addr = 13'h024; dataIn = 32'h3FFFF; {wr3, wr2, wr1, wr0} = 4'hF;
        updateStrobe = 4'hF;
        @(posedge busClk); #1;
        cs = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0; updateStrobe = '0;
        @(negedge busClk) reset = 1'b0;
        check("rst2_mant", 32'(|mantissa), 32'h0);
        check("rst2_bypass", 32'(bypass), 32'hF);
        bus_read(13'h010, rd); check("rst2_status", rd, 32'h0);
        bus_read(13'h024, rd); check("rst2_shadow_ch1", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
